// File: rtl/rbm_image_loader_if.sv
// rbm_image_loader_if
//   Pixel stream handshake between an upstream pixel source and the image
//   loader. A beat transfers on a rising edge where pixel_valid and
//   pixel_ready are both high.
//
//   pixel_valid  source -> loader  beat valid
//   pixel_ready  loader -> source  loader can take a beat this cycle
//   pixel_data   source -> loader  unsigned grayscale pixel
//   pixel_last   source -> loader  final pixel of an image, qualified by pixel_valid
interface rbm_image_loader_if #(
  parameter int pixel_bitlength = 8
);
  logic                       pixel_valid;
  logic                       pixel_ready;
  logic [pixel_bitlength-1:0] pixel_data;
  logic                       pixel_last;

  modport master (
    output pixel_valid,
    output pixel_data,
    output pixel_last,
    input  pixel_ready
  );

  modport slave (
    input  pixel_valid,
    input  pixel_data,
    input  pixel_last,
    output pixel_ready
  );
endinterface

// File: rtl/rbm_image_loader.sv
// rbm_image_loader
//   Upstream feeder for the RBM top. Takes a serial stream of grayscale
//   pixels, binarizes each against a threshold, packs them into an
//   input_dim-bit visible vector (pixel k at bit k) and presents it with
//   data_valid. The vector is held until the RBM's finish handshake
//   completes; only then is the next image accepted.
//
//   clock          system clock, rising edge
//   reset          synchronous, active-low
//   pix            pixel stream (slave side of rbm_image_loader_if)
//   rbm_finish     finish from the RBM
//   data_valid     InputDataPort holds a complete image
//   InputDataPort  packed binary image
//   frame_error    one-cycle pulse when a frame has the wrong length
//   image_count    images consumed by the RBM, wraps
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   LOAD     | accepting pixels into the shadow register
//   HOLD     | image presented on InputDataPort, waiting for rbm_finish
//   RELEASE  | finish seen and counted, waiting for rbm_finish to drop
module rbm_image_loader #(
  parameter int input_dim       = 784,
  parameter int pixel_bitlength = 8,
  parameter int threshold       = 128,
  parameter int count_bitlength = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  rbm_image_loader_if.slave          pix,
  input  logic                       rbm_finish,
  output logic                       data_valid,
  output logic [input_dim-1:0]       InputDataPort,
  output logic                       frame_error,
  output logic [count_bitlength-1:0] image_count
);

  localparam logic [1:0] st_load    = 2'd0;
  localparam logic [1:0] st_hold    = 2'd1;
  localparam logic [1:0] st_release = 2'd2;

  localparam int cnt_w = (input_dim > 1) ? $clog2(input_dim) : 1;
  localparam logic [cnt_w-1:0]           last_idx = cnt_w'(input_dim - 1);
  localparam logic [pixel_bitlength-1:0] thr      = pixel_bitlength'(threshold);

  logic [1:0]           state;
  logic [cnt_w-1:0]     pix_cnt;
  logic [input_dim-1:0] shadow;
  logic [input_dim-1:0] shadow_upd;

  logic beat;
  logic pix_bit;
  logic at_end;
  logic frame_done;
  logic frame_bad;

  // Ready is gated by reset directly so the source sees backpressure for
  // the whole time reset is held, not only from the edge after.
  assign pix.pixel_ready = reset && (state == st_load);

  assign beat       = pix.pixel_valid && pix.pixel_ready;
  assign pix_bit    = (pix.pixel_data >= thr);
  assign at_end     = (pix_cnt == last_idx);
  assign frame_done = beat && at_end && pix.pixel_last;
  // Malformed: pixel_last arrives early, or the final slot arrives without it.
  assign frame_bad  = beat && (at_end != pix.pixel_last);

  // Shadow including the current beat's bit, so the completing beat can be
  // published in the same edge it is accepted.
  always_comb begin
    shadow_upd          = shadow;
    shadow_upd[pix_cnt] = pix_bit;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= st_load;
      pix_cnt       <= '0;
      shadow        <= '0;
      InputDataPort <= '0;
      data_valid    <= 1'b0;
      frame_error   <= 1'b0;
      image_count   <= '0;
    end else begin
      frame_error <= 1'b0;
      case (state)
        st_load: begin
          if (beat) begin
            if (frame_done) begin
              InputDataPort <= shadow_upd;
              data_valid    <= 1'b1;
              pix_cnt       <= '0;
              shadow        <= '0;
              state         <= st_hold;
            end else if (frame_bad) begin
              frame_error <= 1'b1;
              pix_cnt     <= '0;
              shadow      <= '0;
            end else begin
              shadow  <= shadow_upd;
              pix_cnt <= pix_cnt + cnt_w'(1);
            end
          end
        end
        st_hold: begin
          if (rbm_finish) begin
            data_valid  <= 1'b0;
            image_count <= image_count + count_bitlength'(1);
            state       <= st_release;
          end
        end
        st_release: begin
          // Wait for finish to drop so a level-held finish counts once.
          if (!rbm_finish) begin
            state <= st_load;
          end
        end
        default: begin
          data_valid <= 1'b0;
          state      <= st_load;
        end
      endcase
    end
  end

endmodule
